// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - shared widths, FSM state encoding and saturation helper for dot_product_engine
package dp_pkg;

    localparam int DP_DATA_WIDTH = 16;
    localparam int DP_ADDR_WIDTH = 8;
    localparam int DP_ACC_WIDTH  = 40;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dp_state_t;

    // Clamp a sign-extended accumulator to the signed range of a width-bit result.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/dot_product_engine_mac_unit.sv
// rtl/dot_product_engine_mac_unit.sv - registered signed multiply-accumulate with clear, enable and valid
module mac_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         en,
    input  logic                         valid,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    logic signed [2*DATA_WIDTH-1:0] product;

    assign product = a * b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en && valid) begin
            acc <= acc + ACC_WIDTH'(product);
        end
    end

endmodule

// File: rtl/dot_product_engine.sv
// rtl/dot_product_engine.sv - buffer-walking dot product core; DOT_PRODUCT_RELU_EN clamps negative out_q to 0
module dot_product_engine
    import dp_pkg::*;
#(
    parameter int DATA_WIDTH = DP_DATA_WIDTH,
    parameter int ADDR_WIDTH = DP_ADDR_WIDTH,
    parameter int ACC_WIDTH  = DP_ACC_WIDTH,
    parameter int FRAC_BITS  = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [ADDR_WIDTH:0]          len,
    output logic                         in_rd_en,
    output logic [ADDR_WIDTH-1:0]        in_rd_addr,
    input  logic signed [DATA_WIDTH-1:0] in_rd_data,
    output logic                         w_rd_en,
    output logic [ADDR_WIDTH-1:0]        w_rd_addr,
    input  logic signed [DATA_WIDTH-1:0] w_rd_data,
    output logic                         busy,
    output logic                         done,
    output logic signed [ACC_WIDTH-1:0]  acc_out,
    output logic signed [DATA_WIDTH-1:0] out_q
);

    dp_state_t               state;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH:0]     len_q;
    logic [ADDR_WIDTH:0]     idx;
    logic                    valid_q;
    logic                    mac_clear;
    logic                    mac_en;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_shifted;
    logic signed [63:0]      acc_sat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            idx     <= '0;
            valid_q <= 1'b0;
        end else begin
            // Read data lags the issued address by one cycle.
            valid_q <= (state == ST_ISSUE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        len_q  <= len;
                        idx    <= '0;
                        state  <= (len == '0) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    idx <= idx + (ADDR_WIDTH+1)'(1);
                    if (idx == len_q - (ADDR_WIDTH+1)'(1)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: state <= ST_DONE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign in_rd_en   = (state == ST_ISSUE);
    assign w_rd_en    = (state == ST_ISSUE);
    assign in_rd_addr = base_q + idx[ADDR_WIDTH-1:0];
    assign w_rd_addr  = base_q + idx[ADDR_WIDTH-1:0];
    assign busy       = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign done       = (state == ST_DONE);

    assign mac_clear = (state == ST_IDLE) && start;
    assign mac_en    = (state == ST_ISSUE) || (state == ST_DRAIN);

    mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (mac_clear),
        .en    (mac_en),
        .valid (valid_q),
        .a     (in_rd_data),
        .b     (w_rd_data),
        .acc   (acc)
    );

    // The accumulator is cleared only at start, so it already holds the result until the next job.
    assign acc_out     = acc;
    assign acc_shifted = acc >>> FRAC_BITS;
    assign acc_sat     = saturate(64'(acc_shifted), DATA_WIDTH);

    always_comb begin
        out_q = DATA_WIDTH'(acc_sat);
`ifdef DOT_PRODUCT_RELU_EN
        if (acc_sat < 64'sd0) begin
            out_q = '0;
        end
`endif
    end

endmodule

// File: tb/tb_dot_product_engine.sv
// tb/tb_dot_product_engine.sv - randomized self-checking bench for dot_product_engine against a sum-of-products model
module tb_dot_product_engine;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int ACW = 40;
    localparam int FB = 0;
    localparam int DEPTH = 1 << AW;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [AW-1:0]         base_addr;
    logic [AW:0]           len;
    logic                  in_rd_en;
    logic [AW-1:0]         in_rd_addr;
    logic signed [DW-1:0]  in_rd_data;
    logic                  w_rd_en;
    logic [AW-1:0]         w_rd_addr;
    logic signed [DW-1:0]  w_rd_data;
    logic                  busy;
    logic                  done;
    logic signed [ACW-1:0] acc_out;
    logic signed [DW-1:0]  out_q;

    logic signed [DW-1:0] in_mem [DEPTH];
    logic signed [DW-1:0] w_mem  [DEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    dot_product_engine #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ACC_WIDTH  (ACW),
        .FRAC_BITS  (FB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .in_rd_en   (in_rd_en),
        .in_rd_addr (in_rd_addr),
        .in_rd_data (in_rd_data),
        .w_rd_en    (w_rd_en),
        .w_rd_addr  (w_rd_addr),
        .w_rd_data  (w_rd_data),
        .busy       (busy),
        .done       (done),
        .acc_out    (acc_out),
        .out_q      (out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffers with one-cycle registered read.
    always @(posedge clk) begin
        if (in_rd_en) in_rd_data <= in_mem[in_rd_addr];
        if (w_rd_en)  w_rd_data  <= w_mem[w_rd_addr];
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_acc(input int b, input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) begin
            s += longint'(in_mem[(b + i) % DEPTH]) * longint'(w_mem[(b + i) % DEPTH]);
        end
        return s;
    endfunction

    function automatic longint ref_q(input longint a);
        longint s = a >>> FB;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef DOT_PRODUCT_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    // Called right after a posedge (+1); returns right after the next posedge (+1) following done.
    task automatic run_job(input string tag, input int b, input int n, input bit intrude);
        longint e_acc = ref_acc(b, n);
        int n_rd = 0;
        int n_done = 0;
        int done_cyc = -1;
        int lim = n + 40;
        start = 1'b1;
        base_addr = AW'(b);
        len = (AW+1)'(n);
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= lim; cyc++) begin
            @(negedge clk);
            if (intrude && cyc == 2) begin
                start = 1'b1;
                base_addr = 8'd100;
                len = 9'd3;
            end
            if (intrude && cyc == 3) start = 1'b0;
            if (cyc == 1 && n != 0) check({tag, "_busy"}, longint'(busy), 1);
            check({tag, "_w_en"}, longint'(w_rd_en), longint'(in_rd_en));
            if (in_rd_en) begin
                check({tag, "_in_addr"}, longint'(in_rd_addr), longint'((b + n_rd) % DEPTH));
                check({tag, "_w_addr"}, longint'(w_rd_addr), longint'((b + n_rd) % DEPTH));
                n_rd++;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check({tag, "_acc"}, longint'(acc_out), e_acc);
                    check({tag, "_q"}, longint'(out_q), ref_q(e_acc));
                end
            end
            if (done_cyc >= 0 && (!intrude || cyc >= done_cyc + 8)) break;
        end
        check({tag, "_done_cyc"}, longint'(done_cyc), (n == 0) ? 1 : n + 2);
        check({tag, "_rd_count"}, longint'(n_rd), longint'(n));
        if (intrude) check({tag, "_done_count"}, longint'(n_done), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int quiet;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        len = '0;
        for (int i = 0; i < DEPTH; i++) begin
            in_mem[i] = '0;
            w_mem[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_en", longint'(in_rd_en), 0);
        check("rst_w_en", longint'(w_rd_en), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_addr", longint'(in_rd_addr), 0);
        check("rst_acc", longint'(acc_out), 0);
        check("rst_q", longint'(out_q), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            in_mem[i] = DW'(i + 1);
            w_mem[i] = DW'(i + 5);
        end
        run_job("basic", 0, 4, 1'b0);

        in_mem[10] = -16'sd3; in_mem[11] = 16'sd2;
        w_mem[10] = 16'sd4;   w_mem[11] = -16'sd5;
        run_job("neg", 10, 2, 1'b0);

        run_job("len0", 7, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            in_mem[(254 + i) % DEPTH] = DW'($urandom);
            w_mem[(254 + i) % DEPTH] = DW'($urandom);
        end
        run_job("wrap", 254, 4, 1'b1);

        for (int i = 20; i < 24; i++) begin
            in_mem[i] = 16'sd32767;
            w_mem[i] = 16'sd32767;
        end
        run_job("sat_pos", 20, 4, 1'b0);
        for (int i = 30; i < 34; i++) begin
            in_mem[i] = -16'sd32768;
            w_mem[i] = 16'sd32767;
        end
        run_job("sat_neg", 30, 4, 1'b0);

        // Abort a job with a one-edge reset in the middle of issue.
        for (int i = 40; i < 48; i++) begin
            in_mem[i] = DW'($urandom);
            w_mem[i] = DW'($urandom);
        end
        start = 1'b1; base_addr = 8'd40; len = 9'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_en", longint'(in_rd_en), 0);
        check("abort_w_en", longint'(w_rd_en), 0);
        check("abort_busy", longint'(busy), 0);
        check("abort_acc", longint'(acc_out), 0);
        quiet = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) quiet++;
            @(negedge clk);
        end
        check("abort_no_done", longint'(quiet), 0);
        @(posedge clk); #1;
        in_mem[50] = 16'sd3;
        w_mem[50] = 16'sd3;
        run_job("after_abort", 50, 1, 1'b0);

        // Random jobs over a fully random buffer, back to back.
        for (int i = 0; i < DEPTH; i++) begin
            in_mem[i] = DW'($urandom);
            w_mem[i] = DW'($urandom);
        end
        for (int j = 0; j < 30; j++) begin
            int rl;
            rl = (j % 10 == 9) ? 0 : int'($urandom_range(1, 24));
            run_job($sformatf("rand%0d", j), int'($urandom_range(0, DEPTH - 1)), rl, 1'b0);
        end
        run_job("full", int'($urandom_range(0, DEPTH - 1)), DEPTH, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
